// File: rtl/thirtytwo_bit_recursive_carry_adder_pkg.sv
// Shared constants and helpers for the Kogge-Stone prefix adder.
// Width defaults to 32; the prefix depth is always derived from the width.
package thirtytwo_bit_recursive_carry_adder_pkg;

    localparam int unsigned DefaultWidth = 32;

    // The adder has no carry-in port; the carry form below keeps it explicit so it folds away.
    localparam logic CarryIn = 1'b0;

    function automatic int unsigned stages_of(input int unsigned width);
        return $clog2(width);
    endfunction

    function automatic bit is_pow2(input int unsigned width);
        return (width >= 2) && ((width & (width - 1)) == 0);
    endfunction

endpackage

// File: rtl/thirtytwo_bit_recursive_carry_adder_ks_prefix_cell.sv
// Kogge-Stone prefix operator: merges a high (g, p) group with the adjacent lower group.
module ks_prefix_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g_out,
    output logic p_out
);

    assign g_out = g_hi | (p_hi & g_lo);
    assign p_out = p_hi & p_lo;

endmodule

// File: rtl/thirtytwo_bit_recursive_carry_adder.sv
// Unsigned WIDTH-bit adder: Kogge-Stone prefix carries, registered sum and carry-out.
// One result per clock, one cycle of latency, synchronous active-low reset.
module thirtytwo_bit_recursive_carry_adder
    import thirtytwo_bit_recursive_carry_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned STAGES = stages_of(WIDTH);

    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] g_fin;
    logic [WIDTH-1:0] p_fin;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_d;
    logic             cout_q;

    assign g_bit = a & b;
    assign p_bit = a ^ b;

    for (genvar k = 0; k < STAGES; k++) begin : gen_lvl
        localparam int unsigned Span = 1 << k;

        logic [WIDTH-1:0] g_in;
        logic [WIDTH-1:0] p_in;
        logic [WIDTH-1:0] g_out;
        logic [WIDTH-1:0] p_out;

        if (k == 0) begin : gen_src_bits
            assign g_in = g_bit;
            assign p_in = p_bit;
        end else begin : gen_src_prev
            assign g_in = gen_lvl[k-1].g_out;
            assign p_in = gen_lvl[k-1].p_out;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
            if (i >= Span) begin : gen_cell
                ks_prefix_cell u_cell (
                    .g_hi  (g_in[i]),
                    .p_hi  (p_in[i]),
                    .g_lo  (g_in[i-Span]),
                    .p_lo  (p_in[i-Span]),
                    .g_out (g_out[i]),
                    .p_out (p_out[i])
                );
            end else begin : gen_pass
                assign g_out[i] = g_in[i];
                assign p_out[i] = p_in[i];
            end
        end
    end

    assign g_fin = gen_lvl[STAGES-1].g_out;
    assign p_fin = gen_lvl[STAGES-1].p_out;

    // Full group-carry form with a constant-zero carry-in; the P terms simplify away.
    assign carry[0] = CarryIn;
    for (genvar i = 1; i <= WIDTH; i++) begin : gen_carry
        assign carry[i] = g_fin[i-1] | (p_fin[i-1] & CarryIn);
    end

    assign sum_d  = p_bit ^ carry[WIDTH-1:0];
    assign cout_d = carry[WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_thirtytwo_bit_recursive_carry_adder.sv
// Directed and random checks of the registered prefix adder against a 33-bit golden sum.
module tb_thirtytwo_bit_recursive_carry_adder;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;

    logic [32:0] exp_q[$];
    int          n_checks;
    int          n_errors;

    thirtytwo_bit_recursive_carry_adder #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand pair away from the edge, queue its expected result, check after the edge.
    task automatic step(input string tag, input logic [31:0] ai, input logic [31:0] bi,
                        input logic rn);
        logic [32:0] got;
        logic [32:0] expv;
        @(negedge clk);
        a     = ai;
        b     = bi;
        rst_n = rn;
        exp_q.push_back(rn ? ({1'b0, ai} + {1'b0, bi}) : 33'd0);
        @(posedge clk);
        #1;
        got  = {cout, sum};
        expv = exp_q.pop_front();
        n_checks++;
        assert (got === expv) else begin
            n_errors++;
            $error("FAIL %s: observed cout=%0b sum=%08h expected cout=%0b sum=%08h",
                   tag, got[32], got[31:0], expv[32], expv[31:0]);
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rn;
        n_checks = 0;
        n_errors = 0;
        a        = '0;
        b        = '0;
        rst_n    = 1'b0;

        step("reset0", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step("reset1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        step("ones_plus_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        step("zero_plus_ones", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        step("alt_bits", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        step("cc_c006003d", 32'hCCCC_CCCC, 32'hC006_003D, 1'b1);
        step("cc_fff", 32'hCCCC_CCCC, 32'h0000_0FFF, 1'b1);
        step("msb_overflow", 32'h8000_0001, 32'h8000_0007, 1'b1);
        step("small", 32'h0000_0000, 32'h0000_0007, 1'b1);
        step("max_plus_one", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        step("zero_zero", 32'h0000_0000, 32'h0000_0000, 1'b1);

        for (int n = 0; n < 32; n++) begin
            step($sformatf("sweep_%0d", n), 32'hFFFF_FFFF, 32'h1 << n, 1'b1);
        end

        // Mid-stream reset discards the in-flight result, then the next edge captures again.
        step("midreset_pre", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        step("midreset_low", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        step("midreset_post", 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rn = ($urandom_range(0, 49) != 0);
            step("random", ra, rb, rn);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
